// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM response-queue stage.
package mem_stage_pkg;

    // Bit positions inside the one-hot load_op vector
    localparam int unsigned LD_W      = 0;
    localparam int unsigned LD_B      = 1;
    localparam int unsigned LD_H      = 2;
    localparam int unsigned LD_BU     = 3;
    localparam int unsigned LD_HU     = 4;
    localparam int unsigned LOAD_OP_W = 5;

    // One queue slot; the opaque EX->WB payload is stored alongside in its own array
    typedef struct packed {
        logic                 is_mem;
        logic [LOAD_OP_W-1:0] load_op;
        logic [1:0]           addr_lo;
        logic [31:0]          result;
        logic                 done;
    } mem_entry_t;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int unsigned CNT_W(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data alignment and sign/zero extension.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [LOAD_OP_W-1:0] load_op,
    input  logic [1:0]           addr_lo,
    input  logic [31:0]          rdata,
    output logic [31:0]          result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend according to the load type
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        if (load_op[LD_W]) begin
            result = rdata;
        end else if (load_op[LD_B]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[LD_H]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[LD_BU]) begin
            result = {24'd0, byte_sel};
        end else if (load_op[LD_HU]) begin
            result = {16'd0, half_sel};
        end
    end

endmodule

// File: rtl/mem_resp_queue_stage.sv
// MEM stage holding up to DEPTH in-flight instructions; matches in-order
// data_ok responses, drops responses of flushed requests, bypasses the head.
module mem_resp_queue_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PAY_W = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_valid,
    input  logic [PAY_W-1:0]     es_payload,
    input  logic                 es_is_mem,
    input  logic [LOAD_OP_W-1:0] es_load_op,
    input  logic [1:0]           es_addr_lo,
    input  logic [31:0]          es_result,
    output logic                 ms_allowin,
    input  logic                 flush,
    input  logic                 data_ok,
    input  logic [31:0]          rdata,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [PAY_W-1:0]     ms_to_ws_payload,
    output logic [31:0]          ms_to_ws_result,
    output logic                 ms_busy
);

    localparam int unsigned CW    = CNT_W(DEPTH);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_entry_t       ent_q [DEPTH];
    logic [PAY_W-1:0] pay_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    cancel_q;

    logic [PTR_W-1:0] resp_ptr;
    logic             resp_found;
    logic [CW-1:0]    pending;
    mem_entry_t       resp_e;
    mem_entry_t       head_e;
    logic [31:0]      wb_align;
    logic [31:0]      byp_align;
    logic [31:0]      resp_result;
    logic [31:0]      byp_result;
    logic             accept_resp;
    logic             bypass;
    logic             head_ready;
    logic             push;
    logic             pop;
    logic [CW:0]      cancel_sum;
    logic [CW:0]      cancel_flush;

    // Circular pointer addition modulo DEPTH
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // Locate the oldest mem entry still waiting for data and count waiting entries
    always_comb begin
        resp_ptr   = head_q;
        resp_found = 1'b0;
        pending    = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (k < int'(count_q) && ent_q[ptr_add(head_q, 32'(k))].is_mem &&
                !ent_q[ptr_add(head_q, 32'(k))].done) begin
                pending = pending + CW'(1);
                if (!resp_found) begin
                    resp_found = 1'b1;
                    resp_ptr   = ptr_add(head_q, 32'(k));
                end
            end
        end
    end

    assign resp_e = ent_q[resp_ptr];
    assign head_e = ent_q[head_q];

    mem_load_align u_wb_align (
        .load_op (resp_e.load_op),
        .addr_lo (resp_e.addr_lo),
        .rdata   (rdata),
        .result  (wb_align)
    );

    mem_load_align u_byp_align (
        .load_op (head_e.load_op),
        .addr_lo (head_e.addr_lo),
        .rdata   (rdata),
        .result  (byp_align)
    );

    // Handshake, bypass and output selection
    always_comb begin
        accept_resp = data_ok && (cancel_q == '0) && resp_found;
        resp_result = (resp_e.load_op != '0) ? wb_align : resp_e.result;
        byp_result  = (head_e.load_op != '0) ? byp_align : head_e.result;
        bypass      = accept_resp && (resp_ptr == head_q) && !head_e.done;
        head_ready  = (count_q != '0) && (head_e.done || bypass);

        ms_allowin       = ({1'b0, count_q} + {1'b0, cancel_q}) < (CW+1)'(DEPTH);
        ms_busy          = (count_q != '0) || (cancel_q != '0);
        ms_to_ws_valid   = head_ready && !flush;
        ms_to_ws_payload = pay_q[head_q];
        ms_to_ws_result  = bypass ? byp_result : head_e.result;

        push = es_valid && ms_allowin && !flush;
        pop  = ms_to_ws_valid && ws_allowin;

        cancel_sum   = {1'b0, cancel_q} + {1'b0, pending};
        cancel_flush = (data_ok && cancel_sum != '0) ? cancel_sum - (CW+1)'(1) : cancel_sum;
    end

    // Queue state update; flush outranks push, pop and response write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cancel_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
                pay_q[i] <= '0;
            end
        end else if (flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cancel_q <= CW'(cancel_flush);
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
                pay_q[i] <= '0;
            end
        end else begin
            if (data_ok && cancel_q != '0) begin
                cancel_q <= cancel_q - CW'(1);
            end
            if (accept_resp) begin
                ent_q[resp_ptr].done   <= 1'b1;
                ent_q[resp_ptr].result <= resp_result;
            end
            if (push) begin
                ent_q[tail_q] <= '{is_mem:  es_is_mem,
                                   load_op: es_load_op,
                                   addr_lo: es_addr_lo,
                                   result:  es_result,
                                   done:    !es_is_mem};
                pay_q[tail_q] <= es_payload;
                tail_q        <= ptr_add(tail_q, 32'd1);
            end
            if (pop) begin
                head_q <= ptr_add(head_q, 32'd1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_mem_resp_queue_stage.sv
// Directed self-checking bench for mem_resp_queue_stage (DEPTH=2, PAY_W=40).
module tb_mem_resp_queue_stage;

    logic        clk;
    logic        reset;
    logic        es_valid;
    logic [39:0] es_payload;
    logic        es_is_mem;
    logic [4:0]  es_load_op;
    logic [1:0]  es_addr_lo;
    logic [31:0] es_result;
    logic        ms_allowin;
    logic        flush;
    logic        data_ok;
    logic [31:0] rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [39:0] ms_to_ws_payload;
    logic [31:0] ms_to_ws_result;
    logic        ms_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] OP_W  = 5'b00001;
    localparam logic [4:0] OP_B  = 5'b00010;
    localparam logic [4:0] OP_H  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_HU = 5'b10000;

    mem_resp_queue_stage #(.DEPTH(2), .PAY_W(40)) dut (
        .clk              (clk),
        .reset            (reset),
        .es_valid         (es_valid),
        .es_payload       (es_payload),
        .es_is_mem        (es_is_mem),
        .es_load_op       (es_load_op),
        .es_addr_lo       (es_addr_lo),
        .es_result        (es_result),
        .ms_allowin       (ms_allowin),
        .flush            (flush),
        .data_ok          (data_ok),
        .rdata            (rdata),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_payload (ms_to_ws_payload),
        .ms_to_ws_result  (ms_to_ws_result),
        .ms_busy          (ms_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_valid   = 1'b0;
        es_payload = '0;
        es_is_mem  = 1'b0;
        es_load_op = '0;
        es_addr_lo = '0;
        es_result  = '0;
        flush      = 1'b0;
        data_ok    = 1'b0;
        rdata      = '0;
        ws_allowin = 1'b1;
    endtask

    task automatic set_push(input logic [39:0] pay, input logic is_mem, input logic [4:0] op,
                            input logic [1:0] lo, input logic [31:0] res);
        es_valid   = 1'b1;
        es_payload = pay;
        es_is_mem  = is_mem;
        es_load_op = op;
        es_addr_lo = lo;
        es_result  = res;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %0b exp 1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", ms_to_ws_valid); end
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", ms_busy); end
        checks++; if (ms_to_ws_payload !== 40'h0) begin errors++; $display("FAIL rst_payload got %h exp 0", ms_to_ws_payload); end
        checks++; if (ms_to_ws_result !== 32'h0) begin errors++; $display("FAIL rst_result got %h exp 0", ms_to_ws_result); end
        tick();
    endtask

    task automatic test_nonload_burst();
        idle();
        set_push(40'h71, 1'b0, 5'b0, 2'd0, 32'h1000_0001);
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL burst_c0_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            idle();
            if (i < 3) set_push(40'(40'h71 + i), 1'b0, 5'b0, 2'd0, 32'(32'h1000_0001 + i));
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL burst_valid%0d got %0b exp 1", i, ms_to_ws_valid); end
            checks++; if (ms_to_ws_payload !== 40'(40'h70 + i)) begin errors++; $display("FAIL burst_payload%0d got %h exp %h", i, ms_to_ws_payload, 40'(40'h70 + i)); end
            checks++; if (ms_to_ws_result !== 32'(32'h1000_0000 + i)) begin errors++; $display("FAIL burst_result%0d got %h exp %h", i, ms_to_ws_result, 32'(32'h1000_0000 + i)); end
            checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL burst_allowin%0d got %0b exp 1", i, ms_allowin); end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL burst_end_valid got %0b exp 0", ms_to_ws_valid); end
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL burst_end_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    task automatic test_load_align();
        logic [4:0]  ops [5];
        logic [1:0]  los [5];
        logic [31:0] exps [5];
        ops  = '{OP_B, OP_BU, OP_H, OP_HU, OP_W};
        los  = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        exps = '{32'hFFFF_FFF1, 32'h0000_0080, 32'h0000_7F02, 32'h0000_80F1, 32'h80F1_7F02};
        for (int i = 0; i < 5; i++) begin
            idle();
            set_push(40'(40'hA0 + i), 1'b1, ops[i], los[i], 32'hDEAD_0000);
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL align_wait%0d got %0b exp 0", i, ms_to_ws_valid); end
            tick();
            idle();
            data_ok = 1'b1;
            rdata   = 32'h80F1_7F02;
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL align_valid%0d got %0b exp 1", i, ms_to_ws_valid); end
            checks++; if (ms_to_ws_result !== exps[i]) begin errors++; $display("FAIL align_result%0d got %h exp %h", i, ms_to_ws_result, exps[i]); end
            checks++; if (ms_to_ws_payload !== 40'(40'hA0 + i)) begin errors++; $display("FAIL align_payload%0d got %h exp %h", i, ms_to_ws_payload, 40'(40'hA0 + i)); end
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL align_end_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    task automatic test_full();
        idle();
        set_push(40'h11, 1'b1, OP_W, 2'd0, 32'h0);
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL full_c0_allowin got %0b exp 1", ms_allowin); end
        tick();
        idle();
        set_push(40'h22, 1'b1, OP_W, 2'd0, 32'h0);
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL full_c1_allowin got %0b exp 1", ms_allowin); end
        tick();
        idle();
        ws_allowin = 1'b0;
        data_ok    = 1'b1;
        rdata      = 32'h1111_1111;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL full_c2_allowin got %0b exp 0", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL full_byp_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'h1111_1111) begin errors++; $display("FAIL full_byp_result got %h exp 11111111", ms_to_ws_result); end
        tick();
        idle();
        ws_allowin = 1'b0;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL full_hold_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'h1111_1111) begin errors++; $display("FAIL full_hold_result got %h exp 11111111", ms_to_ws_result); end
        checks++; if (ms_to_ws_payload !== 40'h11) begin errors++; $display("FAIL full_hold_payload got %h exp 11", ms_to_ws_payload); end
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL full_hold_allowin got %0b exp 0", ms_allowin); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL full_pop_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL full_pop_allowin got %0b exp 0", ms_allowin); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'h2222_2222;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL full_reopen_allowin got %0b exp 1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL full_second_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'h2222_2222) begin errors++; $display("FAIL full_second_result got %h exp 22222222", ms_to_ws_result); end
        checks++; if (ms_to_ws_payload !== 40'h22) begin errors++; $display("FAIL full_second_payload got %h exp 22", ms_to_ws_payload); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL full_end_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    task automatic test_flush_pending();
        idle();
        set_push(40'h31, 1'b1, OP_W, 2'd0, 32'h0);
        tick();
        idle();
        set_push(40'h32, 1'b1, OP_W, 2'd0, 32'h0);
        tick();
        idle();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fl_c2_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'hBAD0_0001;
        @(negedge clk);
        checks++; if (ms_busy !== 1'b1) begin errors++; $display("FAIL fl_c3_busy got %0b exp 1", ms_busy); end
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL fl_c3_allowin got %0b exp 0", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fl_drop1_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'hBAD0_0002;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL fl_c4_allowin got %0b exp 1", ms_allowin); end
        checks++; if (ms_busy !== 1'b1) begin errors++; $display("FAIL fl_c4_busy got %0b exp 1", ms_busy); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fl_drop2_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        set_push(40'h33, 1'b1, OP_BU, 2'd1, 32'h0);
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL fl_c5_busy got %0b exp 0", ms_busy); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'h0000_AB00;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL fl_third_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'h0000_00AB) begin errors++; $display("FAIL fl_third_result got %h exp 000000ab", ms_to_ws_result); end
        checks++; if (ms_to_ws_payload !== 40'h33) begin errors++; $display("FAIL fl_third_payload got %h exp 33", ms_to_ws_payload); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL fl_end_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    task automatic test_flush_dataok();
        idle();
        set_push(40'h41, 1'b1, OP_W, 2'd0, 32'h0);
        tick();
        idle();
        set_push(40'h42, 1'b1, OP_W, 2'd0, 32'h0);
        tick();
        idle();
        flush   = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'h1234_5678;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fdo_c2_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'h8765_4321;
        @(negedge clk);
        checks++; if (ms_busy !== 1'b1) begin errors++; $display("FAIL fdo_c3_busy got %0b exp 1", ms_busy); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL fdo_c3_allowin got %0b exp 1", ms_allowin); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fdo_c3_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL fdo_c4_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        set_push(40'h51, 1'b1, OP_W, 2'd0, 32'h0);
        tick();
        idle();
        set_push(40'h52, 1'b1, OP_W, 2'd0, 32'h0);
        tick();
        idle();
        flush   = 1'b1;
        data_ok = 1'b1;
        tick();
        idle();
        set_push(40'h53, 1'b1, OP_W, 2'd0, 32'h0);
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rm_c3_allowin got %0b exp 1", ms_allowin); end
        tick();
        idle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL rm_c4_allowin got %0b exp 0", ms_allowin); end
        checks++; if (ms_busy !== 1'b1) begin errors++; $display("FAIL rm_c4_busy got %0b exp 1", ms_busy); end
        tick();
        reset = 1'b0;
        idle();
        set_push(40'h54, 1'b1, OP_H, 2'd2, 32'h0);
        @(negedge clk);
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rm_after_allowin got %0b exp 1", ms_allowin); end
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL rm_after_busy got %0b exp 0", ms_busy); end
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rm_after_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'h8001_0000;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL rm_load_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'hFFFF_8001) begin errors++; $display("FAIL rm_load_result got %h exp ffff8001", ms_to_ws_result); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL rm_end_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        set_push(40'h61, 1'b0, 5'b0, 2'd0, 32'h600D_0001);
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_c0_valid got %0b exp 0", ms_to_ws_valid); end
        tick();
        idle();
        set_push(40'h62, 1'b1, OP_W, 2'd0, 32'h0);
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_c1_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'h600D_0001) begin errors++; $display("FAIL b2b_c1_result got %h exp 600d0001", ms_to_ws_result); end
        tick();
        idle();
        set_push(40'h63, 1'b0, 5'b0, 2'd0, 32'h600D_0002);
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_c2_valid got %0b exp 0", ms_to_ws_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL b2b_c2_allowin got %0b exp 1", ms_allowin); end
        tick();
        idle();
        data_ok = 1'b1;
        rdata   = 32'hCAFE_BABE;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_c3_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_result !== 32'hCAFE_BABE) begin errors++; $display("FAIL b2b_c3_result got %h exp cafebabe", ms_to_ws_result); end
        checks++; if (ms_to_ws_payload !== 40'h62) begin errors++; $display("FAIL b2b_c3_payload got %h exp 62", ms_to_ws_payload); end
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL b2b_c3_allowin got %0b exp 0", ms_allowin); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_c4_valid got %0b exp 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_payload !== 40'h63) begin errors++; $display("FAIL b2b_c4_payload got %h exp 63", ms_to_ws_payload); end
        checks++; if (ms_to_ws_result !== 32'h600D_0002) begin errors++; $display("FAIL b2b_c4_result got %h exp 600d0002", ms_to_ws_result); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (ms_busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %0b exp 0", ms_busy); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_nonload_burst();
        test_load_align();
        test_full();
        test_flush_pending();
        test_flush_dataok();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
